m1_image_loader: RTL

//  Writer side of the M1 image memory: accepts a raster pixel stream, packs 16 pixels per 128-bit word,

---
 rtl/m1_image_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/m1_image_loader.sv
// rtl/m1_image_loader.sv - M1 image writer: packs a pixel stream into 128-bit words and writes a frame
//
// Purpose: accepts one raster frame per load_req, packs WORD_PIX pixels per word (first pixel in
//          the LSBs), writes the words to consecutive M1 addresses starting at the selected bank
//          base, then pulses frame_done/start. Sustains one pixel per cycle.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   load_req, bank_sel       frame start pulse and target bank (sampled together, IDLE only)
//   pix_valid, pix_data      pixel stream input
//   pix_ready                pixel accepted this cycle when pix_valid is also high
//   M1_WriteBus/Address/Enable  word write port, one strobe cycle per word
//   busy                     frame in progress (cycle after accept until the done cycle)
//   frame_done, start        one-cycle pulses once the final word is committed
module m1_image_loader #(
    parameter int PIXEL_W     = 8,
    parameter int WORD_PIX    = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_WORDS   = 1024,
    parameter int BANK_OFFSET = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_req,
    input  logic                        bank_sel,
    input  logic                        pix_valid,
    input  logic [PIXEL_W-1:0]          pix_data,
    output logic                        pix_ready,
    output logic [PIXEL_W*WORD_PIX-1:0] M1_WriteBus,
    output logic [ADDR_W-1:0]           M1_WriteAddress,
    output logic                        M1_WriteEnable,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        start
);

    localparam int WORD_W = PIXEL_W * WORD_PIX;
    localparam int PCNT_W = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
    localparam int WCNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [WORD_W-1:0]   wbus_q, wbus_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                we_q, we_d;
    logic                xfer;
    logic                word_full;
    logic                last_word;

    assign pix_ready       = (state_q == S_FILL);
    assign busy            = (state_q == S_FILL) || (state_q == S_FLUSH);
    assign frame_done      = (state_q == S_DONE);
    assign start           = (state_q == S_DONE);
    assign M1_WriteBus     = wbus_q;
    assign M1_WriteAddress = waddr_q;
    assign M1_WriteEnable  = we_q;

    assign xfer      = pix_ready && pix_valid;
    assign word_full = (pix_cnt_q == PCNT_W'(WORD_PIX - 1));
    assign last_word = (word_cnt_q == WCNT_W'(NUM_WORDS - 1));

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        word_cnt_d = word_cnt_q;
        base_d     = base_q;
        pack_d     = pack_q;
        wbus_d     = wbus_q;
        waddr_d    = waddr_q;
        we_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d    = S_FILL;
                    base_d     = bank_sel ? ADDR_W'(BANK_OFFSET) : '0;
                    pix_cnt_d  = '0;
                    word_cnt_d = '0;
                    pack_d     = '0;
                end
            end
            S_FILL: begin
                if (xfer) begin
                    pack_d[pix_cnt_q * PIXEL_W +: PIXEL_W] = pix_data;
                    if (word_full) begin
                        // The completed word (including this pixel) moves to the write
                        // register, so packing of the next word starts without a bubble.
                        wbus_d     = pack_d;
                        waddr_d    = base_q + ADDR_W'(word_cnt_q);
                        we_d       = 1'b1;
                        pix_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                        if (last_word) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + PCNT_W'(1);
                    end
                end
            end
            // The final word's strobe is on the bus during FLUSH.
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            base_q     <= '0;
            pack_q     <= '0;
            wbus_q     <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            base_q     <= base_d;
            pack_q     <= pack_d;
            wbus_q     <= wbus_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
        end
    end

endmodule
